// File: rtl/cp0_reg.sv
// Coprocessor-0 system register file: Count/Compare timer, Status, Cause, EPC,
// read-only PRId/Config, and a combinational read mux for mfc0.
module cp0_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  raddr_i,
   input  logic [5:0]  int_i,
   output logic [31:0] data_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] config_o,
   output logic [31:0] prid_o,
   output logic        timer_int_o
);

   localparam logic [4:0] ADDR_COUNT   = 5'd9;
   localparam logic [4:0] ADDR_COMPARE = 5'd11;
   localparam logic [4:0] ADDR_STATUS  = 5'd12;
   localparam logic [4:0] ADDR_CAUSE   = 5'd13;
   localparam logic [4:0] ADDR_EPC     = 5'd14;
   localparam logic [4:0] ADDR_PRID    = 5'd15;
   localparam logic [4:0] ADDR_CONFIG  = 5'd16;

   localparam logic [31:0] STATUS_RST = 32'h1000_0000;
   localparam logic [31:0] CONFIG_RST = 32'h0000_8000;
   localparam logic [31:0] PRID_RST   = 32'h004C_0102;

   // IP[7:2] always tracks the interrupt lines; only IV, WP and IP[1:0] take software writes.
   function automatic logic [31:0] cause_next(input logic [31:0] cur, input logic wr,
                                              input logic [31:0] wdata, input logic [5:0] irq);
      logic [1:0] ivwp;
      logic [1:0] ipsw;
      ivwp = wr ? wdata[23:22] : cur[23:22];
      ipsw = wr ? wdata[9:8]   : cur[9:8];
      return {8'h00, ivwp, 6'h00, irq, ipsw, 8'h00};
   endfunction

   logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic match;

   assign wr_count   = we_i && (waddr_i == ADDR_COUNT);
   assign wr_compare = we_i && (waddr_i == ADDR_COMPARE);
   assign wr_status  = we_i && (waddr_i == ADDR_STATUS);
   assign wr_cause   = we_i && (waddr_i == ADDR_CAUSE);
   assign wr_epc     = we_i && (waddr_i == ADDR_EPC);
   assign match      = (compare_o != 32'h0) && (count_o == compare_o);

   always_ff @(posedge clk) begin
      if (rst) begin
         count_o     <= 32'h0;
         compare_o   <= 32'h0;
         status_o    <= STATUS_RST;
         cause_o     <= 32'h0;
         epc_o       <= 32'h0;
         config_o    <= CONFIG_RST;
         prid_o      <= PRID_RST;
         timer_int_o <= 1'b0;
      end else begin
         count_o  <= wr_count ? data_i : count_o + 32'd1;
         cause_o  <= cause_next(cause_o, wr_cause, data_i, int_i);
         config_o <= CONFIG_RST;
         prid_o   <= PRID_RST;
         if (wr_status) status_o <= data_i;
         if (wr_epc)    epc_o    <= data_i;
         // A Compare write acknowledges the timer and beats a coincident match.
         if (wr_compare) begin
            compare_o   <= data_i;
            timer_int_o <= 1'b0;
         end else if (match) begin
            timer_int_o <= 1'b1;
         end
      end
   end

   always_comb begin
      data_o = 32'h0;
      case (raddr_i)
         ADDR_COUNT:   data_o = count_o;
         ADDR_COMPARE: data_o = compare_o;
         ADDR_STATUS:  data_o = status_o;
         ADDR_CAUSE:   data_o = cause_o;
         ADDR_EPC:     data_o = epc_o;
         ADDR_PRID:    data_o = prid_o;
         ADDR_CONFIG:  data_o = config_o;
         default:      data_o = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: reset values, Count wrap, timer match/ack,
// Cause masking, read-only registers, read mux and mid-run reset.
module tb_cp0_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] data_i;
   logic [4:0]  raddr_i;
   logic [5:0]  int_i;
   logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
   logic        timer_int_o;

   int total = 0;
   int bad   = 0;

   cp0_reg dut (
      .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
      .raddr_i(raddr_i), .int_i(int_i), .data_o(data_o), .count_o(count_o),
      .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
      .config_o(config_o), .prid_o(prid_o), .timer_int_o(timer_int_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; data_i = d;
   endtask

   initial begin
      rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; data_i = 32'h0; raddr_i = 5'd0; int_i = 6'h0;
      tick(); tick();
      check("rst_count",   count_o,   32'h0);
      check("rst_compare", compare_o, 32'h0);
      check("rst_status",  status_o,  32'h1000_0000);
      check("rst_cause",   cause_o,   32'h0);
      check("rst_epc",     epc_o,     32'h0);
      check("rst_config",  config_o,  32'h0000_8000);
      check("rst_prid",    prid_o,    32'h004C_0102);
      check("rst_timer",   {31'h0, timer_int_o}, 32'h0);

      rst = 1'b0;
      tick(); check("count_1", count_o, 32'd1);
      tick(); check("count_2", count_o, 32'd2);
      raddr_i = 5'd12; #1 check("rd_status", data_o, 32'h1000_0000);

      // Count wrap
      wr(5'd9, 32'hFFFF_FFFE); tick(); we_i = 1'b0;
      check("wrap_a", count_o, 32'hFFFF_FFFE);
      tick(); check("wrap_b", count_o, 32'hFFFF_FFFF);
      tick(); check("wrap_c", count_o, 32'h0);

      // Timer match and acknowledge
      wr(5'd9, 32'h0C);  tick(); check("cnt_0c", count_o, 32'h0C);
      wr(5'd11, 32'h10); tick(); we_i = 1'b0;
      check("cmp_10", compare_o, 32'h10);
      check("cnt_0d", count_o, 32'h0D);
      tick(); tick(); tick();
      check("cnt_10", count_o, 32'h10);
      check("tmr_at_eq", {31'h0, timer_int_o}, 32'h0);
      tick(); check("tmr_set", {31'h0, timer_int_o}, 32'h1);
      tick(); check("tmr_hold", {31'h0, timer_int_o}, 32'h1);
      check("cnt_12", count_o, 32'h12);
      wr(5'd11, 32'h20); tick(); we_i = 1'b0;
      check("tmr_ack", {31'h0, timer_int_o}, 32'h0);

      // Compare write coincident with a match
      wr(5'd9, 32'h1F); tick(); we_i = 1'b0;
      tick(); check("cnt_20", count_o, 32'h20);
      check("tmr_pre", {31'h0, timer_int_o}, 32'h0);
      wr(5'd11, 32'h40); tick(); we_i = 1'b0;
      check("tmr_wr_wins", {31'h0, timer_int_o}, 32'h0);
      check("cmp_40", compare_o, 32'h40);
      tick(); check("tmr_no_late", {31'h0, timer_int_o}, 32'h0);

      // Cause masking and interrupt sampling
      int_i = 6'b101001; wr(5'd13, 32'hFFFF_FFFF); tick(); we_i = 1'b0;
      check("cause_wr", cause_o, 32'h00C0_A700);
      raddr_i = 5'd13; #1 check("rd_cause", data_o, 32'h00C0_A700);
      int_i = 6'h0; tick();
      check("cause_irq0", cause_o, 32'h00C0_0300);
      int_i = 6'b010110; tick();
      check("cause_irq1", cause_o, 32'h00C0_5B00);
      int_i = 6'h0;

      // Status / EPC
      wr(5'd12, 32'hABCD_0001); tick();
      wr(5'd14, 32'h1234_5678); tick(); we_i = 1'b0;
      check("status_wr", status_o, 32'hABCD_0001);
      check("epc_wr",    epc_o,    32'h1234_5678);
      raddr_i = 5'd14; #1 check("rd_epc", data_o, 32'h1234_5678);

      // Back-to-back writes keep the last value
      wr(5'd14, 32'h1111_1111); tick();
      wr(5'd14, 32'h2222_2222); tick(); we_i = 1'b0;
      check("epc_b2b", epc_o, 32'h2222_2222);

      // Read-only registers and unmapped read
      wr(5'd15, 32'h0); tick();
      wr(5'd16, 32'h0); tick(); we_i = 1'b0;
      check("prid_ro",   prid_o,   32'h004C_0102);
      check("config_ro", config_o, 32'h0000_8000);
      raddr_i = 5'd5;  #1 check("rd_unmapped", data_o, 32'h0);
      raddr_i = 5'd15; #1 check("rd_prid",     data_o, 32'h004C_0102);
      raddr_i = 5'd16; #1 check("rd_config",   data_o, 32'h0000_8000);
      raddr_i = 5'd11; #1 check("rd_compare",  data_o, 32'h40);

      // Mid-run reset beats a write
      rst = 1'b1; wr(5'd12, 32'hFFFF_FFFF); tick(); we_i = 1'b0;
      check("mrst_status", status_o, 32'h1000_0000);
      check("mrst_count",  count_o,  32'h0);
      check("mrst_cmp",    compare_o, 32'h0);
      check("mrst_epc",    epc_o,    32'h0);
      rst = 1'b0; tick();
      check("mrst_cnt1", count_o, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
